// File: rtl/hdlc_bus_sched.sv
// Bus master for the HDLC core register interface: round-robin Tx sharing
// between two requesters, Rx frame draining, status polling and abort.
module hdlc_bus_sched #(
  parameter int unsigned MAX_LEN  = 126,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] tx_req,
  input  logic [7:0] tx_len0,
  input  logic [7:0] tx_len1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_grant,
  output logic       tx_rd,
  output logic [1:0] tx_done,
  output logic [1:0] tx_rej,
  input  logic       abort_req,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  output logic       rx_err,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut
);

  localparam logic [7:0] MAX_L    = 8'(MAX_LEN);
  localparam logic [7:0] GAP_INIT = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [4:0] {
    IDLE, TX_CHK, TX_SC_RD, TX_SC_WAIT, TX_SC_GAP, TX_LOAD, TX_START,
    TX_POLL_GAP, TX_POLL_RD, TX_POLL_WAIT, TX_ABORT,
    RX_SC_RD, RX_SC_WAIT, RX_LEN_RD, RX_LEN_WAIT, RX_DATA_RD, RX_DATA_WAIT, RX_DROP
  } state_t;

  state_t     state;
  logic [7:0] cnt, gap, wdata;
  logic       gidx, rr, abort_pend, aborted;
  logic [1:0] req_eff;
  logic       win, abort_now;
  logic [7:0] glen, gdata;

  // A requester whose done/rej is pulsing this cycle has not yet dropped its request
  assign req_eff   = tx_req & ~(tx_done | tx_rej);
  assign win       = req_eff[rr] ? rr : ~rr;
  assign glen      = gidx ? tx_len1 : tx_len0;
  assign gdata     = gidx ? tx_data1 : tx_data0;
  assign abort_now = (abort_req | abort_pend) & ~aborted;
  // Buffer writes carry the requester's live byte so tx_rd and the write share a cycle
  assign DataIn    = (state == TX_LOAD) ? gdata : wdata;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;  cnt <= '0;  gap <= '0;  wdata <= '0;
      gidx <= 1'b0;  rr <= 1'b0;  abort_pend <= 1'b0;  aborted <= 1'b0;
      tx_grant <= '0;  tx_rd <= 1'b0;  tx_done <= '0;  tx_rej <= '0;
      rx_data <= '0;  rx_valid <= 1'b0;  rx_last <= 1'b0;  rx_err <= 1'b0;
      Address <= '0;  WriteEnable <= 1'b0;  ReadEnable <= 1'b0;
    end else begin
      ReadEnable <= 1'b0;  WriteEnable <= 1'b0;  tx_rd <= 1'b0;
      tx_done <= '0;  tx_rej <= '0;
      rx_valid <= 1'b0;  rx_last <= 1'b0;  rx_err <= 1'b0;
      case (state)
        IDLE: begin
          aborted <= 1'b0;  abort_pend <= 1'b0;
          if (rx_ready) begin
            Address <= 3'd2;  ReadEnable <= 1'b1;  state <= RX_SC_RD;
          end else if (|req_eff) begin
            gidx <= win;  tx_grant <= win ? 2'b10 : 2'b01;  state <= TX_CHK;
          end
        end
        TX_CHK: begin
          if (glen == 8'd0 || glen > MAX_L) begin
            tx_rej[gidx] <= 1'b1;  tx_grant <= '0;  state <= IDLE;
          end else begin
            cnt <= glen;  Address <= 3'd0;  ReadEnable <= 1'b1;  state <= TX_SC_RD;
          end
        end
        TX_SC_RD: state <= TX_SC_WAIT;
        TX_SC_WAIT: begin
          if (DataOut[0]) begin
            Address <= 3'd1;  WriteEnable <= 1'b1;  tx_rd <= 1'b1;  state <= TX_LOAD;
          end else begin
            gap <= GAP_INIT;  state <= TX_SC_GAP;
          end
        end
        TX_SC_GAP: begin
          if (gap == 8'd0) begin
            Address <= 3'd0;  ReadEnable <= 1'b1;  state <= TX_SC_RD;
          end else gap <= gap - 8'd1;
        end
        TX_LOAD: begin
          WriteEnable <= 1'b1;
          if (cnt == 8'd1) begin
            Address <= 3'd0;  wdata <= 8'h02;  state <= TX_START;
          end else begin
            cnt <= cnt - 8'd1;  tx_rd <= 1'b1;
          end
        end
        TX_START: begin
          gap <= GAP_INIT;  state <= TX_POLL_GAP;
        end
        TX_POLL_GAP: begin
          if (abort_now) begin
            Address <= 3'd0;  wdata <= 8'h04;  WriteEnable <= 1'b1;
            aborted <= 1'b1;  state <= TX_ABORT;
          end else if (gap == 8'd0) begin
            Address <= 3'd0;  ReadEnable <= 1'b1;  state <= TX_POLL_RD;
          end else gap <= gap - 8'd1;
        end
        TX_POLL_RD: begin
          if (abort_req) abort_pend <= 1'b1;
          state <= TX_POLL_WAIT;
        end
        TX_POLL_WAIT: begin
          if (DataOut[0]) begin
            if (DataOut[3]) tx_rej[gidx] <= 1'b1;
            else begin
              tx_done[gidx] <= 1'b1;  rr <= ~gidx;
            end
            tx_grant <= '0;  state <= IDLE;
          end else if (abort_now) begin
            Address <= 3'd0;  wdata <= 8'h04;  WriteEnable <= 1'b1;
            aborted <= 1'b1;  state <= TX_ABORT;
          end else begin
            gap <= GAP_INIT;  state <= TX_POLL_GAP;
          end
        end
        TX_ABORT: begin
          gap <= GAP_INIT;  state <= TX_POLL_GAP;
        end
        RX_SC_RD: state <= RX_SC_WAIT;
        RX_SC_WAIT: begin
          if (|DataOut[4:2]) begin
            Address <= 3'd2;  wdata <= 8'h02;  WriteEnable <= 1'b1;
            rx_err <= 1'b1;  state <= RX_DROP;
          end else begin
            Address <= 3'd4;  ReadEnable <= 1'b1;  state <= RX_LEN_RD;
          end
        end
        RX_LEN_RD: state <= RX_LEN_WAIT;
        RX_LEN_WAIT: begin
          cnt <= DataOut;
          if (DataOut == 8'd0) begin
            Address <= 3'd2;  wdata <= 8'h02;  WriteEnable <= 1'b1;
            rx_err <= 1'b1;  state <= RX_DROP;
          end else begin
            Address <= 3'd3;  ReadEnable <= 1'b1;  state <= RX_DATA_RD;
          end
        end
        RX_DATA_RD: state <= RX_DATA_WAIT;
        RX_DATA_WAIT: begin
          rx_valid <= 1'b1;  rx_data <= DataOut;  rx_last <= (cnt == 8'd1);
          if (cnt == 8'd1) state <= IDLE;
          else begin
            cnt <= cnt - 8'd1;  ReadEnable <= 1'b1;  state <= RX_DATA_RD;
          end
        end
        RX_DROP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_bus_sched.sv
// Directed bench for hdlc_bus_sched with a small behavioural HDLC register model.
module tb_hdlc_bus_sched;

  logic       Clk = 1'b0, Rst = 1'b1;
  logic [1:0] tx_req = '0;
  logic [7:0] tx_len0 = '0, tx_len1 = '0, tx_data0, tx_data1;
  logic [1:0] tx_grant, tx_done, tx_rej;
  logic       tx_rd, abort_req = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last, rx_err;
  logic [2:0] Address;
  logic       WriteEnable, ReadEnable;
  logic [7:0] DataIn, DataOut;

  hdlc_bus_sched dut (
    .Clk(Clk), .Rst(Rst), .tx_req(tx_req), .tx_len0(tx_len0), .tx_len1(tx_len1),
    .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_grant(tx_grant), .tx_rd(tx_rd),
    .tx_done(tx_done), .tx_rej(tx_rej), .abort_req(abort_req), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_err(rx_err),
    .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  // Requester byte sources and core model state
  logic [7:0] bytes0 [0:127];
  logic [7:0] bytes1 [0:127];
  logic [7:0] rx_bytes [0:7];
  logic [7:0] rx_sc_val = '0, rx_len_val = '0;
  int idx0, idx1, busy, rx_idx, busy_reload = 2;
  logic abt;

  assign tx_data0 = bytes0[idx0[6:0]];
  assign tx_data1 = bytes1[idx1[6:0]];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      DataOut <= '0;  busy <= 0;  abt <= 1'b0;  rx_idx <= 0;  idx0 <= 0;  idx1 <= 0;
    end else begin
      if (ReadEnable)
        case (Address)
          3'd0: begin
            DataOut <= {4'b0, abt, 2'b0, (busy == 0)};
            if (busy != 0) busy <= busy - 1;
          end
          3'd2: DataOut <= rx_sc_val;
          3'd3: begin DataOut <= rx_bytes[rx_idx[2:0]]; rx_idx <= rx_idx + 1; end
          3'd4: DataOut <= rx_len_val;
          default: DataOut <= '0;
        endcase
      if (WriteEnable && Address == 3'd0) begin
        if (DataIn[1]) begin busy <= busy_reload; abt <= 1'b0; end
        if (DataIn[2]) abt <= 1'b1;
      end
      if (!rx_ready) rx_idx <= 0;
      if (tx_rd && tx_grant[0]) idx0 <= idx0 + 1;
      if (tx_rd && tx_grant[1]) idx1 <= idx1 + 1;
      if (tx_done[0] || tx_rej[0]) idx0 <= 0;
      if (tx_done[1] || tx_rej[1]) idx1 <= 0;
    end
  end

  // Bus and handshake monitor
  logic [2:0] wr_a [$];
  logic [7:0] wr_d [$];
  logic [2:0] rd_a [$];
  logic [7:0] rxd_q [$];
  logic       rxl_q [$];
  int         gr_log [$];
  int done0 = 0, done1 = 0, rej0 = 0, rej1 = 0, rxerr_n = 0;
  bit both_bad = 0, txrd_bad = 0, multi_bad = 0;
  logic [1:0] prev_grant = '0;

  always @(posedge Clk) begin
    if (!Rst) begin
      if (WriteEnable) begin wr_a.push_back(Address); wr_d.push_back(DataIn); end
      if (ReadEnable) rd_a.push_back(Address);
      if (ReadEnable && WriteEnable) both_bad = 1;
      if (tx_rd !== (WriteEnable && Address == 3'd1)) txrd_bad = 1;
      if ($countones(tx_grant) > 1) multi_bad = 1;
      if (tx_grant != 2'b00 && prev_grant == 2'b00) gr_log.push_back(tx_grant[1] ? 1 : 0);
      prev_grant = tx_grant;
      if (rx_valid) begin rxd_q.push_back(rx_data); rxl_q.push_back(rx_last); end
      if (rx_err) rxerr_n++;
      if (tx_done[0]) done0++;
      if (tx_done[1]) done1++;
      if (tx_rej[0]) rej0++;
      if (tx_rej[1]) rej1++;
    end else prev_grant = '0;
  end

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({tx_grant, tx_rd, tx_done, tx_rej, rx_data, rx_valid, rx_last, rx_err,
         Address, WriteEnable, ReadEnable, DataIn} !== '0) begin
      errors++;  $display("FAIL reset_outputs grant=%b addr=%0d we=%b re=%b din=%h", tx_grant, Address, WriteEnable, ReadEnable, DataIn);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if ({tx_grant, WriteEnable, ReadEnable} !== '0) begin
      errors++;  $display("FAIL idle_quiet grant=%b we=%b re=%b required 0", tx_grant, WriteEnable, ReadEnable);
    end
  endtask

  task automatic test_round_robin();
    int n = 0, gbase = gr_log.size(), wbase = wr_a.size(), d0 = done0, d1 = done1;
    int seq;
    tx_req = 2'b11;
    for (int i = 0; i < 800; i++) begin
      @(negedge Clk);
      if (tx_done != 2'b00) n++;
      if (n == 4) begin tx_req = '0; break; end
    end
    tx_req = '0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_timeout frames=%0d required 4", n); end
    repeat (3) @(negedge Clk);
    checks++;
    if (gr_log.size() - gbase != 4) begin
      errors++;  $display("FAIL rr_grant_count got %0d required 4", gr_log.size() - gbase);
    end else begin
      seq = gr_log[gbase] * 8 + gr_log[gbase+1] * 4 + gr_log[gbase+2] * 2 + gr_log[gbase+3];
      checks++;
      if (seq != 5) begin errors++; $display("FAIL rr_order got %b required 0101", 4'(seq)); end
    end
    checks++;
    if (done0 - d0 != 2 || done1 - d1 != 2) begin
      errors++;  $display("FAIL rr_done got %0d/%0d required 2/2", done0 - d0, done1 - d1);
    end
    checks++;
    if (wr_a.size() - wbase != 14) begin
      errors++;  $display("FAIL rr_write_count got %0d required 14", wr_a.size() - wbase);
    end
    checks++;
    if (multi_bad) begin errors++; $display("FAIL rr_onehot got multiple grants required one-hot"); end
  endtask

  task automatic test_single_tx();
    logic [2:0] ea [0:3];
    logic [7:0] ed [0:3];
    int wbase = wr_a.size(), rbase = rd_a.size(), d0 = done0, r0 = rej0;
    bit got = 0;
    ea[0] = 3'd1; ed[0] = 8'hA1;  ea[1] = 3'd1; ed[1] = 8'hB2;
    ea[2] = 3'd1; ed[2] = 8'hC3;  ea[3] = 3'd0; ed[3] = 8'h02;
    tx_req = 2'b01;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (tx_done[0]) begin got = 1; tx_req = '0; break; end
    end
    tx_req = '0;
    checks++;
    if (!got) begin errors++; $display("FAIL tx1_timeout no tx_done[0]"); end
    repeat (2) @(negedge Clk);
    checks++;
    if (wr_a.size() - wbase != 4) begin
      errors++;  $display("FAIL tx1_write_count got %0d required 4", wr_a.size() - wbase);
    end else
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_a[wbase+k] !== ea[k] || wr_d[wbase+k] !== ed[k]) begin
          errors++;
          $display("FAIL tx1_write%0d got a%0d=%h required a%0d=%h", k, wr_a[wbase+k], wr_d[wbase+k], ea[k], ed[k]);
        end
      end
    checks++;
    if (rd_a.size() - rbase < 2 || rd_a[rbase] !== 3'd0) begin
      errors++;  $display("FAIL tx1_first_read reads=%0d required Tx_SC read first", rd_a.size() - rbase);
    end
    checks++;
    if (done0 - d0 != 1 || rej0 != r0) begin
      errors++;  $display("FAIL tx1_pulses done=%0d rej=%0d required 1/0", done0 - d0, rej0 - r0);
    end
    checks++;
    if (txrd_bad || both_bad) begin
      errors++;  $display("FAIL tx1_strobes txrd_bad=%0b both_bad=%0b required 0/0", txrd_bad, both_bad);
    end
  endtask

  task automatic test_rx_frame();
    int rbase = rd_a.size(), qbase = rxd_q.size(), e = rxerr_n;
    logic [2:0] er [0:6];
    bit got = 0;
    er[0] = 3'd2; er[1] = 3'd4;
    for (int k = 2; k < 7; k++) er[k] = 3'd3;
    rx_sc_val = 8'h01;  rx_len_val = 8'd5;
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33; rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;
    rx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (rx_valid && rx_last) begin got = 1; rx_ready = 1'b0; break; end
    end
    rx_ready = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL rx_timeout no rx_last"); end
    repeat (3) @(negedge Clk);
    checks++;
    if (rd_a.size() - rbase != 7) begin
      errors++;  $display("FAIL rx_read_count got %0d required 7", rd_a.size() - rbase);
    end else
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (rd_a[rbase+k] !== er[k]) begin
          errors++;  $display("FAIL rx_read%0d got addr %0d required %0d", k, rd_a[rbase+k], er[k]);
        end
      end
    checks++;
    if (rxd_q.size() - qbase != 5) begin
      errors++;  $display("FAIL rx_byte_count got %0d required 5", rxd_q.size() - qbase);
    end else
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (rxd_q[qbase+k] !== rx_bytes[k] || rxl_q[qbase+k] !== (k == 4)) begin
          errors++;
          $display("FAIL rx_byte%0d got %h last=%b required %h last=%b", k, rxd_q[qbase+k], rxl_q[qbase+k], rx_bytes[k], (k == 4));
        end
      end
    checks++;
    if (rxerr_n != e) begin errors++; $display("FAIL rx_no_err got %0d required 0", rxerr_n - e); end
  endtask

  task automatic test_rx_drop(input logic [7:0] sc, input logic [7:0] len, input int nreads);
    int wbase = wr_a.size(), rbase = rd_a.size(), qbase = rxd_q.size(), e = rxerr_n;
    bit got = 0;
    rx_sc_val = sc;  rx_len_val = len;  rx_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (rx_err) begin got = 1; rx_ready = 1'b0; break; end
    end
    rx_ready = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL rxdrop_timeout sc=%h len=%0d no rx_err", sc, len); end
    repeat (3) @(negedge Clk);
    checks++;
    if (wr_a.size() - wbase != 1 || wr_a[wbase] !== 3'd2 || wr_d[wbase] !== 8'h02) begin
      errors++;  $display("FAIL rxdrop_write sc=%h got %0d writes required one 0x02 to addr 2", sc, wr_a.size() - wbase);
    end
    checks++;
    if (rd_a.size() - rbase != nreads || rxd_q.size() != qbase || rxerr_n - e != 1) begin
      errors++;
      $display("FAIL rxdrop_counts reads=%0d valid=%0d err=%0d required %0d/0/1", rd_a.size() - rbase, rxd_q.size() - qbase, rxerr_n - e, nreads);
    end
  endtask

  task automatic test_abort();
    int wbase = wr_a.size(), d0 = done0, r0 = rej0;
    bit started = 0, got = 0, seen4 = 0;
    busy_reload = 4;  tx_len0 = 8'd2;  tx_req = 2'b01;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (WriteEnable && Address == 3'd0 && DataIn == 8'h02) begin started = 1; break; end
    end
    repeat (3) @(negedge Clk);
    abort_req = 1'b1;
    @(negedge Clk);
    abort_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (tx_rej[0] || tx_done[0]) begin got = 1; tx_req = '0; break; end
    end
    tx_req = '0;
    checks++;
    if (!started || !got) begin errors++; $display("FAIL abort_timeout started=%0b ended=%0b", started, got); end
    repeat (2) @(negedge Clk);
    for (int k = wbase; k < wr_a.size(); k++)
      if (wr_a[k] == 3'd0 && wr_d[k] == 8'h04) seen4 = 1;
    checks++;
    if (!seen4) begin errors++; $display("FAIL abort_write got none required 0x04 to addr 0"); end
    checks++;
    if (rej0 - r0 != 1 || done0 != d0) begin
      errors++;  $display("FAIL abort_pulses rej=%0d done=%0d required 1/0", rej0 - r0, done0 - d0);
    end
    busy_reload = 2;  tx_len0 = 8'd3;
  endtask

  task automatic test_bad_len(input logic [7:0] len);
    int wbase = wr_a.size(), rbase = rd_a.size(), r0 = rej0, d0 = done0;
    bit got = 0;
    tx_len0 = len;  tx_req = 2'b01;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (tx_rej[0]) begin got = 1; tx_req = '0; break; end
    end
    tx_req = '0;
    repeat (2) @(negedge Clk);
    checks++;
    if (!got || rej0 - r0 != 1 || done0 != d0) begin
      errors++;  $display("FAIL badlen_%0d rej=%0d done=%0d required 1/0", len, rej0 - r0, done0 - d0);
    end
    checks++;
    if (wr_a.size() != wbase || rd_a.size() != rbase) begin
      errors++;  $display("FAIL badlen_bus_%0d writes=%0d reads=%0d required 0/0", len, wr_a.size() - wbase, rd_a.size() - rbase);
    end
    tx_len0 = 8'd3;
  endtask

  task automatic test_max_len();
    int wbase = wr_a.size(), d1 = done1;
    bit got = 0;
    for (int k = 0; k < 128; k++) bytes1[k] = 8'(k);
    tx_len1 = 8'd126;  tx_req = 2'b10;
    for (int i = 0; i < 800; i++) begin
      @(negedge Clk);
      if (tx_done[1] || tx_rej[1]) begin got = 1; tx_req = '0; break; end
    end
    tx_req = '0;
    repeat (2) @(negedge Clk);
    checks++;
    if (!got || done1 - d1 != 1) begin errors++; $display("FAIL maxlen_done got %0d required 1", done1 - d1); end
    checks++;
    if (wr_a.size() - wbase != 127 || wr_d[wr_d.size()-2] !== 8'd125) begin
      errors++;  $display("FAIL maxlen_writes got %0d required 127 ending with byte 7d", wr_a.size() - wbase);
    end
  endtask

  task automatic test_reset_mid_load();
    bit got = 0;
    tx_len0 = 8'd3;  tx_req = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (WriteEnable && Address == 3'd1) begin got = 1; break; end
    end
    Rst = 1'b1;
    #1;
    checks++;
    if (!got || {tx_grant, tx_rd, tx_done, tx_rej, rx_valid, rx_last, rx_err,
                 Address, WriteEnable, ReadEnable, DataIn} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load in_load=%0b grant=%b tx_rd=%b we=%b addr=%0d din=%h required all 0", got, tx_grant, tx_rd, WriteEnable, Address, DataIn);
    end
    tx_req = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) begin bytes0[k] = 8'h00; bytes1[k] = 8'h00; end
    for (int k = 0; k < 8; k++) rx_bytes[k] = 8'h00;
    bytes0[0] = 8'hA1; bytes0[1] = 8'hB2; bytes0[2] = 8'hC3;
    bytes1[0] = 8'h5A; bytes1[1] = 8'h6B;
    tx_len0 = 8'd3;  tx_len1 = 8'd2;
    test_reset();
    test_round_robin();
    test_single_tx();
    test_rx_frame();
    test_rx_drop(8'h04, 8'd5, 1);
    test_rx_drop(8'h01, 8'd0, 2);
    test_abort();
    test_bad_len(8'd0);
    test_bad_len(8'd127);
    test_max_len();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
